// File: rtl/bram_arb_pkg.sv
// Shared types and sizing helpers for the two-requester BRAM port arbiter.
package bram_arb_pkg;

  localparam int unsigned NUM_RQ = 2;

  typedef logic [0:0] rq_id_t;

  typedef struct packed {
    logic   valid;
    rq_id_t id;
  } tag_t;

  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/bram_arb_tag_pipe.sv
// Fixed-depth shift register carrying read tags alongside the BRAM read latency.
module bram_arb_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic ACLK,
  input  logic ARESET,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [DEPTH-1:0] stage;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      stage <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one BRAM port between two requesters, with read data
// returned in grant order and tagged to the requester that issued it.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                                  ACLK,
  input  logic                                  ARESET,
  input  logic [NUM_RQ-1:0]                     rq_req,
  input  logic [NUM_RQ-1:0]                     rq_we,
  input  logic [NUM_RQ*ADDR_W-1:0]              rq_addr,
  input  logic [NUM_RQ*DATA_W-1:0]              rq_wdata,
  input  logic [NUM_RQ*be_width(DATA_W)-1:0]    rq_be,
  output logic [NUM_RQ-1:0]                     rq_gnt,
  output logic [NUM_RQ-1:0]                     rq_rvalid,
  output logic [DATA_W-1:0]                     rq_rdata,
  output logic                                  bram_en,
  output logic [be_width(DATA_W)-1:0]           bram_we,
  output logic [ADDR_W-1:0]                     bram_addr,
  output logic [DATA_W-1:0]                     bram_wdata,
  input  logic [DATA_W-1:0]                     bram_rdata
);

  localparam int unsigned BE_W = be_width(DATA_W);

  rq_id_t              last_gnt;
  rq_id_t              gnt_id;
  logic                gnt_any;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BE_W-1:0]     sel_be;
  logic                iss_rd;
  rq_id_t              iss_id;
  tag_t                tag_in;
  tag_t                tag_out;

  // On a tie, favour the requester that was not granted last.
  always_comb begin
    rq_gnt = '0;
    case (rq_req)
      2'b01:   rq_gnt = 2'b01;
      2'b10:   rq_gnt = 2'b10;
      2'b11:   rq_gnt = (last_gnt == 1'b0) ? 2'b10 : 2'b01;
      default: rq_gnt = '0;
    endcase
  end

  assign gnt_any = |rq_gnt;
  assign gnt_id  = rq_id_t'(rq_gnt[1]);

  always_comb begin
    sel_we    = rq_we[gnt_id];
    sel_addr  = rq_addr[ADDR_W-1:0];
    sel_wdata = rq_wdata[DATA_W-1:0];
    sel_be    = rq_be[BE_W-1:0];
    if (gnt_id == 1'b1) begin
      sel_addr  = rq_addr[2*ADDR_W-1:ADDR_W];
      sel_wdata = rq_wdata[2*DATA_W-1:DATA_W];
      sel_be    = rq_be[2*BE_W-1:BE_W];
    end
  end

  // BRAM issue registers; iss_rd/iss_id describe the access on the port this cycle.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      last_gnt   <= 1'b1;
      bram_en    <= 1'b0;
      bram_we    <= '0;
      bram_addr  <= '0;
      bram_wdata <= '0;
      iss_rd     <= 1'b0;
      iss_id     <= '0;
    end else begin
      bram_en <= gnt_any;
      bram_we <= (gnt_any && sel_we) ? sel_be : '0;
      iss_rd  <= gnt_any & ~sel_we;
      iss_id  <= gnt_id;
      if (gnt_any) begin
        last_gnt   <= gnt_id;
        bram_addr  <= sel_addr;
        bram_wdata <= sel_wdata;
      end
    end
  end

  assign tag_in = '{valid: iss_rd, id: iss_id};

  bram_arb_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // Tag reaches the pipe output in the cycle bram_rdata is valid.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rq_rvalid <= '0;
      rq_rdata  <= '0;
    end else begin
      rq_rvalid <= NUM_RQ'(tag_out.valid) << tag_out.id;
      if (tag_out.valid) begin
        rq_rdata <= bram_rdata;
      end
    end
  end

endmodule
